// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60), axis total helpers and the sync polarity type.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic {
        POL_LOW  = 1'b0,
        POL_HIGH = 1'b1
    } pol_e;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync flags decoded from the next count,
// so the flags are registered yet aligned with the count they describe.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CW     = 11,
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          active_next,
    output logic          sync_next,
    output logic          wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [CW-1:0] count_next;

    assign wrap       = (count == LAST);
    assign count_next = wrap ? '0 : count + ONE;

    // Reset parks on the last back-porch position, which is neither active nor sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= LAST;
            active_next <= 1'b0;
            sync_next   <= 1'b0;
        end else if (step) begin
            count       <= count_next;
            active_next <= (count_next < ACTIVE_END);
            sync_next   <= (count_next >= SYNC_START) && (count_next < SYNC_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axis counters, polarity-adjusted syncs, display enable
// and line/frame start strobes, all advancing on the pixel step enable EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW       = 11,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    output logic [CW-1:0] HCOUNT,
    output logic [CW-1:0] VCOUNT,
    output logic          HS,
    output logic          VS,
    output logic          DE,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int   H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int   V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam pol_e HS_LEVEL = pol_e'(HS_POL);
    localparam pol_e VS_LEVEL = pol_e'(VS_POL);

    if (H_TOTAL > (1 << CW)) begin : g_h_range
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_v_range
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_SYNC < 1 || H_BP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_min_width
        $error("vga_timing_gen: sync and back porch widths must be at least 1");
    end

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic h_sync;
    logic v_sync;
    logic v_step;

    assign v_step = EN & h_wrap;

    vga_axis_counter #(
        .CW     (CW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk         (CLK),
        .reset       (RST),
        .step        (EN),
        .count       (HCOUNT),
        .active_next (h_active),
        .sync_next   (h_sync),
        .wrap        (h_wrap)
    );

    vga_axis_counter #(
        .CW     (CW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk         (CLK),
        .reset       (RST),
        .step        (v_step),
        .count       (VCOUNT),
        .active_next (v_active),
        .sync_next   (v_sync),
        .wrap        (v_wrap)
    );

    // Strobes fire only on the stepping edge itself, so they stay one CLK wide whatever EN does next.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= EN & h_wrap;
            FRAME_START <= EN & h_wrap & v_wrap;
        end
    end

    assign DE = h_active & v_active;
    assign HS = h_sync ? HS_LEVEL : ~HS_LEVEL;
    assign VS = v_sync ? VS_LEVEL : ~VS_LEVEL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small-parameter and default-parameter instances driven with
// randomised EN/RST and compared every cycle against a linear-position raster model.
module tb_vga_timing_gen;

    localparam int CW = 11;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int h, v;
        bit hs, vs, de, ls, fs;
    } exp_t;

    cfg_t s_cfg = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0};
    cfg_t d_cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          s_rst = 1'b1, s_en = 1'b0;
    logic [CW-1:0] s_hcount, s_vcount;
    logic          s_hs, s_vs, s_de, s_ls, s_fs;

    logic          d_rst = 1'b1, d_en = 1'b0;
    logic [CW-1:0] d_hcount, d_vcount;
    logic          d_hs, d_vs, d_de, d_ls, d_fs;

    vga_timing_gen #(
        .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_small (
        .CLK(CLK), .RST(s_rst), .EN(s_en), .HCOUNT(s_hcount), .VCOUNT(s_vcount),
        .HS(s_hs), .VS(s_vs), .DE(s_de), .LINE_START(s_ls), .FRAME_START(s_fs)
    );

    vga_timing_gen #(
        .CW(CW), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_default (
        .CLK(CLK), .RST(d_rst), .EN(d_en), .HCOUNT(d_hcount), .VCOUNT(d_vcount),
        .HS(d_hs), .VS(d_vs), .DE(d_de), .LINE_START(d_ls), .FRAME_START(d_fs)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t s_q[$];
    exp_t d_q[$];
    exp_t s_model;
    exp_t d_model;

    // Raster position as a single index into the frame; everything else is derived from it.
    function automatic exp_t model_step(input exp_t cur, input bit rst, input bit en, input cfg_t c);
        exp_t n;
        int   ht, vt, pos;
        n  = cur;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (rst) begin
            n.h  = ht - 1;
            n.v  = vt - 1;
            n.de = 1'b0;
            n.hs = ~c.hp;
            n.vs = ~c.vp;
        end else if (en) begin
            pos  = (cur.v * ht + cur.h + 1) % (ht * vt);
            n.h  = pos % ht;
            n.v  = pos / ht;
            n.de = (n.h < c.ha) && (n.v < c.va);
            n.hs = (n.h >= c.ha + c.hf && n.h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
            n.vs = (n.v >= c.va + c.vf && n.v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
            n.ls = (n.h == 0);
            n.fs = (pos == 0);
        end
        return n;
    endfunction

    task automatic checkOne(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input int h, input int v,
                               input logic hs, input logic vs, input logic de,
                               input logic ls, input logic fs);
        checkOne({tag, ".HCOUNT"},      h,       e.h);
        checkOne({tag, ".VCOUNT"},      v,       e.v);
        checkOne({tag, ".HS"},          int'(hs), int'(e.hs));
        checkOne({tag, ".VS"},          int'(vs), int'(e.vs));
        checkOne({tag, ".DE"},          int'(de), int'(e.de));
        checkOne({tag, ".LINE_START"},  int'(ls), int'(e.ls));
        checkOne({tag, ".FRAME_START"}, int'(fs), int'(e.fs));
    endtask

    task automatic applyStimulusSmall(input bit rst, input bit en);
        s_rst   = rst;
        s_en    = en;
        s_model = model_step(s_model, rst, en, s_cfg);
        s_q.push_back(s_model);
        @(negedge CLK);
    endtask

    task automatic applyStimulusDefault(input bit rst, input bit en);
        d_rst   = rst;
        d_en    = en;
        d_model = model_step(d_model, rst, en, d_cfg);
        d_q.push_back(d_model);
        @(negedge CLK);
    endtask

    initial begin : monitor_small
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (s_q.size() > 0) begin
                e = s_q.pop_front();
                checkOutput("small", e, int'(s_hcount), int'(s_vcount), s_hs, s_vs, s_de, s_ls, s_fs);
            end
        end
    end

    initial begin : monitor_default
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (d_q.size() > 0) begin
                e = d_q.pop_front();
                checkOutput("dflt", e, int'(d_hcount), int'(d_vcount), d_hs, d_vs, d_de, d_ls, d_fs);
            end
        end
    end

    initial begin : main
        bit found;
        s_model = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        d_model = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fork
            begin : small_seq
                repeat (3) applyStimulusSmall(1'b1, 1'b0);
                for (int k = 0; k < 260; k++) applyStimulusSmall(1'b0, 1'b1);
                for (int k = 0; k < 800; k++) applyStimulusSmall(1'b0, (k % 3) == 0);
                for (int k = 0; k < 1500; k++)
                    applyStimulusSmall($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
                found = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    if (s_model.h == 5 && s_model.v == 2) begin
                        found = 1'b1;
                        break;
                    end
                    applyStimulusSmall(1'b0, 1'b1);
                end
                checkOne("small.reach_5_2", int'(found), 1);
                applyStimulusSmall(1'b1, 1'b1);
                for (int k = 0; k < 130; k++) applyStimulusSmall(1'b0, 1'b1);
            end
            begin : default_seq
                repeat (2) applyStimulusDefault(1'b1, 1'b0);
                for (int k = 0; k < 2500; k++) applyStimulusDefault(1'b0, 1'b1);
                for (int k = 0; k < 600; k++)
                    applyStimulusDefault($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
            end
        join
        for (int k = 0; k < 5 && (s_q.size() + d_q.size()) > 0; k++) @(negedge CLK);
        checkOne("scoreboard_drained", s_q.size() + d_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the single-axis horizontal sync counter.
- Generates both the horizontal and vertical counters, HS/VS with configurable polarity, display-enable, and line/frame start strobes.
- Supports a pixel-clock enable, so it can run from a system clock faster than the pixel rate.
- Sits between the clock/reset logic and the pixel pipeline (frame-buffer reader, pattern generators).

Parameters:
- CW, 11: counter width. Elaboration error if H_TOTAL > 2^CW or V_TOTAL > 2^CW.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels. Borders are folded into the porches.
- H_SYNC, 96: horizontal sync width in pixels. Must be >= 1.
- H_BP, 48: horizontal back porch in pixels. Must be >= 1.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width in lines. Must be >= 1.
- V_BP, 33: vertical back porch in lines. Must be >= 1.
- HS_POL, 0: HS active level. 0 = active-low, 1 = active-high.
- VS_POL, 0: VS active level. 0 = active-low, 1 = active-high.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  pixel step enable. Counters advance only on cycles where EN=1.
- HCOUNT  out  CW  current pixel column, range 0..H_TOTAL-1
- VCOUNT  out  CW  current line, range 0..V_TOTAL-1
- HS  out  1  horizontal sync, polarity set by HS_POL
- VS  out  1  vertical sync, polarity set by VS_POL
- DE  out  1  display enable: 1 when HCOUNT<H_ACTIVE and VCOUNT<V_ACTIVE
- LINE_START  out  1  one-CLK strobe on entry to HCOUNT=0
- FRAME_START  out  1  one-CLK strobe on entry to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_ parameters.
- Reset state (RST=1 at a CLK edge):
  - HCOUNT=H_TOTAL-1, VCOUNT=V_TOTAL-1 (last blanking pixel of the frame).
  - DE=0, HS=~HS_POL, VS=~VS_POL, LINE_START=0, FRAME_START=0.
- RST has priority over EN. Reset mid-frame takes effect at the next edge; no partial pulse.
- Counter stepping, on a CLK edge with EN=1:
  - If HCOUNT=H_TOTAL-1: HCOUNT<=0, and VCOUNT steps (VCOUNT<=0 if VCOUNT=V_TOTAL-1, else VCOUNT+1).
  - Otherwise HCOUNT<=HCOUNT+1.
  - With EN=0, the counters and HS/VS/DE hold.
- Output alignment:
  - HS/VS/DE are registered. They are decoded from the next counter values, so they change on the same edge as HCOUNT/VCOUNT.
  - Zero skew: every output always describes the currently displayed (HCOUNT,VCOUNT). No combinational paths from inputs to outputs.
- Sync decode:
  - HS is active while H_ACTIVE+H_FP <= HCOUNT < H_ACTIVE+H_FP+H_SYNC.
  - VS is active while V_ACTIVE+V_FP <= VCOUNT < V_ACTIVE+V_FP+V_SYNC.
  - VS therefore changes only together with HCOUNT 0.
  - Output level = active ? POL : ~POL.
- Strobes:
  - LINE_START=1 for exactly the one CLK cycle after an EN edge that moved HCOUNT to 0, else 0.
  - FRAME_START is the same, additionally requiring VCOUNT to move to 0.
  - Strobes remain single-cycle when EN is held low afterwards.
- First frame: the first EN=1 edge after reset release gives (0,0), DE=1, LINE_START=1, FRAME_START=1.
- Arithmetic: all compares are unsigned at width CW, using parameter constants only.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (active/porch/sync per axis);
  - H_TOTAL/V_TOTAL helper functions;
  - a polarity enum (POL_LOW=0, POL_HIGH=1).
- Sub-module vga_axis_counter, instantiated twice (H and V):
  - inputs: step, reset;
  - parameters: ACTIVE/FP/SYNC/BP;
  - outputs: count, registered active_next/sync_next, wrap.
  - The H instance's wrap ANDed with EN drives the V instance's step.
- The top level adds polarity inversion, DE = h_active & v_active, and strobe generation.

Test Plan:
1. Small params, EN=1 constant:
   - Params: H 8/2/3/2 (H_TOTAL=15), V 4/1/2/1 (V_TOTAL=8).
   - Release RST -> first edge gives HCOUNT=0, VCOUNT=0, DE=1, LINE_START=1, FRAME_START=1.
   - LINE_START every 15 cycles, FRAME_START every 120 cycles.
2. Same params, HS_POL=0 -> HS=0 exactly for HCOUNT 10,11,12 (3 cycles per line). DE=1 only for HCOUNT 0..7 with VCOUNT 0..3.
3. Same params -> VS=0 exactly for VCOUNT 5,6 (30 consecutive cycles). VS edges coincide with HCOUNT=0.
4. EN high one cycle in three:
   - Counters advance only on EN.
   - FRAME_START period is 360 CLK, and each strobe is exactly 1 CLK wide.
   - HS/VS/DE hold during EN=0.
5. Assert RST for one cycle at HCOUNT=5, VCOUNT=2 -> next cycle HCOUNT=14, VCOUNT=7, DE=0, HS=VS=1, strobes 0. The next EN gives (0,0) with FRAME_START=1.
6. Default params with HS_POL=1, VS_POL=1, EN=1:
   - 420000 cycles per frame; DE high for 307200 cycles per frame.
   - HS high 96 cycles per line; VS high 1600 cycles per frame.
